// File: rtl/gbe_tx_pkg.sv
// Shared definitions for the GbE UDP transmit path: control-word layout and default
// FIFO geometries for the payload (packet) and per-packet control FIFOs.
package gbe_tx_pkg;

    localparam int unsigned CTRL_SIZE_MSB = 63;
    localparam int unsigned CTRL_SIZE_LSB = 48;
    localparam int unsigned CTRL_PORT_MSB = 47;
    localparam int unsigned CTRL_PORT_LSB = 32;
    localparam int unsigned CTRL_IP_MSB   = 31;
    localparam int unsigned CTRL_IP_LSB   = 0;

    localparam int unsigned PKT_FIFO_WIDTH        = 8;
    localparam int unsigned PKT_FIFO_DEPTH        = 2048;
    localparam int unsigned PKT_PROG_FULL_THRESH  = 1536;
    localparam int unsigned CTRL_FIFO_WIDTH       = 64;
    localparam int unsigned CTRL_FIFO_DEPTH       = 64;
    localparam int unsigned CTRL_PROG_FULL_THRESH = 48;

    typedef struct packed {
        logic [15:0] size;
        logic [15:0] dest_port;
        logic [31:0] dest_ip;
    } ctrl_word_t;

    function automatic logic [63:0] pack_ctrl(input logic [15:0] size,
                                              input logic [15:0] dest_port,
                                              input logic [31:0] dest_ip);
        ctrl_word_t w;
        w.size      = size;
        w.dest_port = dest_port;
        w.dest_ip   = dest_ip;
        return w;
    endfunction

endpackage

// File: rtl/gbe_tx_fifo_ram.sv
// Simple dual-port RAM for the transmit FIFOs: synchronous write, synchronous registered
// read (read-first on address collision); the read register clears on reset.
module gbe_tx_fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/gbe_tx_sync_fifo.sv
// Single-clock FIFO for the GbE UDP transmit path, standard or first-word-fall-through read.
// Define GBE_FIFO_COUNT_EN to expose the registered occupancy on data_count.
module gbe_tx_sync_fifo
    import gbe_tx_pkg::*;
#(
    parameter int unsigned WIDTH            = PKT_FIFO_WIDTH,
    parameter int unsigned DEPTH            = PKT_FIFO_DEPTH,
    parameter int unsigned PROG_FULL_THRESH = PKT_PROG_FULL_THRESH,
    parameter int unsigned FWFT             = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   prog_full,
    output logic                   overflow
`ifdef GBE_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] data_count
`endif
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, ram_cnt;
    logic              prog_full_q, prog_full_d, overflow_q, overflow_d;
    logic              mid_valid_q, mid_valid_d, out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  dout_q, dout_d, ram_rdata;
    logic              full, wr_accept, rd_accept, ram_re, mid_move;

    gbe_tx_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // In FWFT mode the RAM read register is a prefetch stage (mid) feeding dout_q; the
    // occupancy counts words in both stages, and only a word already on dout can be popped.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        mid_move  = 1'b0;
        ram_cnt   = count_q;
        if (FWFT != 0) begin
            rd_accept = rd_en && out_valid_q;
            mid_move  = mid_valid_q && (!out_valid_q || rd_accept);
            ram_cnt   = count_q - CNT_W'(mid_valid_q) - CNT_W'(out_valid_q);
            ram_re    = (ram_cnt != '0) && (!mid_valid_q || mid_move);
        end else begin
            rd_accept = rd_en && (count_q != '0);
            ram_re    = rd_accept;
        end
        wr_accept = wr_en && (!full || rd_accept);

        count_d = count_q;
        if (wr_accept && !rd_accept) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_accept && rd_accept) begin
            count_d = count_q - CNT_W'(1);
        end

        wr_ptr_d    = wr_ptr_q + ADDR_W'(wr_accept);
        rd_ptr_d    = rd_ptr_q + ADDR_W'(ram_re);
        mid_valid_d = ram_re ? 1'b1 : (mid_move ? 1'b0 : mid_valid_q);
        out_valid_d = mid_move ? 1'b1 : (rd_accept ? 1'b0 : out_valid_q);
        dout_d      = mid_move ? ram_rdata : dout_q;
        prog_full_d = (count_d >= CNT_W'(PROG_FULL_THRESH));
        overflow_d  = wr_en && !wr_accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            prog_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            mid_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            prog_full_q <= prog_full_d;
            overflow_q  <= overflow_d;
            mid_valid_q <= mid_valid_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
        end
    end

    assign dout      = (FWFT != 0) ? dout_q : ram_rdata;
    assign empty     = (count_q == '0);
    assign prog_full = prog_full_q;
    assign overflow  = overflow_q;
`ifdef GBE_FIFO_COUNT_EN
    assign data_count = count_q;
`endif

endmodule

// File: tb/tb_gbe_tx_sync_fifo.sv
// Bench for gbe_tx_sync_fifo: a standard-read byte FIFO checked against a queue model
// (table vectors, corner sequences, random traffic) and an FWFT control-word FIFO.
module tb_gbe_tx_sync_fifo;
    import gbe_tx_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned THRESH = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  s_din = '0;
    logic        s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [7:0]  s_dout;
    logic        s_empty, s_prog_full, s_overflow;
    logic [63:0] f_din = '0;
    logic        f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [63:0] f_dout;
    logic        f_empty, f_prog_full, f_overflow;
`ifdef GBE_FIFO_COUNT_EN
    logic [4:0]  s_cnt, f_cnt;
`endif

    always #5 clk = ~clk;

    gbe_tx_sync_fifo #(
        .WIDTH (8), .DEPTH (DEPTH), .PROG_FULL_THRESH (THRESH), .FWFT (0)
    ) u_std (
        .clk (clk), .rst (rst), .din (s_din), .wr_en (s_wr_en), .rd_en (s_rd_en),
        .dout (s_dout), .empty (s_empty), .prog_full (s_prog_full), .overflow (s_overflow)
`ifdef GBE_FIFO_COUNT_EN
        , .data_count (s_cnt)
`endif
    );

    gbe_tx_sync_fifo #(
        .WIDTH (64), .DEPTH (DEPTH), .PROG_FULL_THRESH (THRESH), .FWFT (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .din (f_din), .wr_en (f_wr_en), .rd_en (f_rd_en),
        .dout (f_dout), .empty (f_empty), .prog_full (f_prog_full), .overflow (f_overflow)
`ifdef GBE_FIFO_COUNT_EN
        , .data_count (f_cnt)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  model_q[$];
    logic [7:0]  m_dout = '0;
    logic [63:0] fq[$];

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] dout;
        logic       empty;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_wr_en = 1'b0; s_rd_en = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0;
        tick();
        rst = 1'b0;
        model_q.delete();
        m_dout = '0;
    endtask

    // Drive one cycle on the standard FIFO and compare against the queue model.
    task automatic std_step(input logic wr, input logic rd, input logic [7:0] d);
        int unsigned occ;
        logic rd_ok, wr_ok, m_ovf;
        s_wr_en = wr; s_rd_en = rd; s_din = d;
        tick();
        occ   = model_q.size();
        rd_ok = rd && (occ != 0);
        wr_ok = wr && ((occ < DEPTH) || rd_ok);
        if (rd_ok) m_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(d);
        m_ovf = wr && !wr_ok;
        check("std_dout", 64'(s_dout), 64'(m_dout));
        check("std_empty", 64'(s_empty), 64'(model_q.size() == 0));
        check("std_prog_full", 64'(s_prog_full), 64'(model_q.size() >= THRESH));
        check("std_overflow", 64'(s_overflow), 64'(m_ovf));
`ifdef GBE_FIFO_COUNT_EN
        check("std_count", 64'(s_cnt), 64'(model_q.size()));
`endif
        s_wr_en = 1'b0; s_rd_en = 1'b0;
    endtask

    initial begin
        logic [63:0] w;
        int unsigned wp, rp;

        tbl[0] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'h33, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h11, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h22, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 8'h33, 1'b1};

        #1;
        do_reset();
        check("rst_s_empty", 64'(s_empty), 64'd1);
        check("rst_s_prog_full", 64'(s_prog_full), 64'd0);
        check("rst_s_overflow", 64'(s_overflow), 64'd0);
        check("rst_s_dout", 64'(s_dout), 64'd0);
        check("rst_f_empty", 64'(f_empty), 64'd1);
        check("rst_f_dout", f_dout, 64'd0);

        for (int i = 0; i < 8; i++) begin
            std_step(tbl[i].wr, tbl[i].rd, tbl[i].din);
            check("tbl_dout", 64'(s_dout), 64'(tbl[i].dout));
            check("tbl_empty", 64'(s_empty), 64'(tbl[i].empty));
        end

        // prog_full threshold crossing
        do_reset();
        for (int i = 0; i < 12; i++) begin
            std_step(1'b1, 1'b0, 8'($urandom));
            if (i == 10) check("pf_before_thresh", 64'(s_prog_full), 64'd0);
        end
        check("pf_at_thresh", 64'(s_prog_full), 64'd1);
        std_step(1'b0, 1'b1, 8'h00);
        check("pf_after_read", 64'(s_prog_full), 64'd0);

        // overflow on a full FIFO, then drain in order plus one read on empty
        do_reset();
        for (int i = 0; i < 16; i++) std_step(1'b1, 1'b0, 8'(i + 8'h40));
        std_step(1'b1, 1'b0, 8'hEE);
        check("ovf_pulse", 64'(s_overflow), 64'd1);
        std_step(1'b0, 1'b0, 8'h00);
        check("ovf_one_cycle", 64'(s_overflow), 64'd0);
        for (int i = 0; i < 16; i++) begin
            std_step(1'b0, 1'b1, 8'h00);
            check("ovf_drain_order", 64'(s_dout), 64'(i + 8'h40));
        end
        std_step(1'b0, 1'b1, 8'h00);
        check("empty_read_hold", 64'(s_dout), 64'h4f);

        // full with simultaneous read and write
        for (int i = 0; i < 16; i++) std_step(1'b1, 1'b0, 8'(i + 8'h80));
        for (int i = 0; i < 5; i++) begin
            std_step(1'b1, 1'b1, 8'(i + 8'hC0));
            check("full_rw_no_ovf", 64'(s_overflow), 64'd0);
            check("full_rw_order", 64'(s_dout), 64'(i + 8'h80));
        end
        for (int i = 0; i < 16; i++) std_step(1'b0, 1'b1, 8'h00);
        check("full_rw_last", 64'(s_dout), 64'hC4);

        // reset in the middle of a fill
        for (int i = 0; i < 13; i++) std_step(1'b1, 1'b0, 8'($urandom));
        check("pre_rst_pf", 64'(s_prog_full), 64'd1);
        s_wr_en = 1'b1; s_din = 8'h99;
        do_reset();
        check("mid_rst_empty", 64'(s_empty), 64'd1);
        check("mid_rst_pf", 64'(s_prog_full), 64'd0);
        check("mid_rst_dout", 64'(s_dout), 64'd0);
        std_step(1'b1, 1'b0, 8'hA5);
        std_step(1'b0, 1'b1, 8'h00);
        check("post_rst_data", 64'(s_dout), 64'hA5);

        // random traffic in phases of differing read/write pressure
        for (int i = 0; i < 600; i++) begin
            case (i / 150)
                0: begin wp = 70; rp = 30; end
                1: begin wp = 30; rp = 70; end
                2: begin wp = 90; rp = 90; end
                default: begin wp = 50; rp = 50; end
            endcase
            std_step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
        end

        // FWFT: single control word
        do_reset();
        w = pack_ctrl(16'h0040, 16'h1F90, 32'h0A00_0001);
        f_wr_en = 1'b1; f_din = w;
        tick();
        f_wr_en = 1'b0;
        check("fwft_empty_low", 64'(f_empty), 64'd0);
        tick();
        tick();
        check("fwft_dout_shown", f_dout, w);
        check("fwft_still_nonempty", 64'(f_empty), 64'd0);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        check("fwft_popped_empty", 64'(f_empty), 64'd1);

        // FWFT: back-to-back pops of a burst
        fq.delete();
        for (int i = 0; i < 5; i++) begin
            w = {$urandom, $urandom};
            fq.push_back(w);
            f_wr_en = 1'b1; f_din = w;
            tick();
        end
        f_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check("fwft_burst_dout", f_dout, fq.pop_front());
            check("fwft_burst_empty", 64'(f_empty), 64'd0);
            f_rd_en = 1'b1;
            tick();
        end
        f_rd_en = 1'b0;
        check("fwft_burst_done", 64'(f_empty), 64'd1);

        // FWFT: fill, overflow, drain
        fq.delete();
        for (int i = 0; i < 16; i++) begin
            w = {$urandom, $urandom};
            fq.push_back(w);
            f_wr_en = 1'b1; f_din = w;
            tick();
        end
        check("fwft_full_pf", 64'(f_prog_full), 64'd1);
        f_din = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        f_wr_en = 1'b0;
        check("fwft_ovf", 64'(f_overflow), 64'd1);
        tick();
        check("fwft_ovf_clear", 64'(f_overflow), 64'd0);
        for (int i = 0; i < 16; i++) begin
            check("fwft_drain", f_dout, fq.pop_front());
            f_rd_en = 1'b1;
            tick();
        end
        f_rd_en = 1'b0;
        check("fwft_drain_empty", 64'(f_empty), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
